// File: rtl/cp0_unit_pkg.sv
// cp0_unit_pkg: shared constants for the CP0 register block.
//   - CP0 register numbers used by mtc0/mfc0
//   - ExcCode values that also latch BadVAddr
//   - Status / Cause bit positions
//   - stall vector width and bypass channel layout
package cp0_unit_pkg;

  // Pipeline stall vector: bit STALL_RD is the stage issuing the cp0 read,
  // bit STALL_NX is the stage after it.
  localparam int STALL_W  = 6;
  localparam int STALL_RD = 3;
  localparam int STALL_NX = 4;

  // One bypass channel on fwd_bus_i: {we, addr[4:0], data[31:0]}.
  localparam int FWD_W  = 38;
  localparam int FWD_WE = 37;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int CA_BD  = 31;
  localparam int CA_TI  = 30;

  // Address-error exceptions are the only ones that report a faulting address.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_fwd_buf.sv
// cp0_fwd_buf: bank of NUM_FWD mtc0 bypass buffers with priority match.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   stall_rd      stall of the stage issuing the cp0 read
//   stall_nx      stall of the following stage
//   fwd_bus       NUM_FWD channels of {we, addr[4:0], data[31:0]}
//   raddr         mfc0 register number
//   hit           some buffered write targets raddr
//   hit_data      data of the lowest-index (youngest) matching channel
module cp0_fwd_buf
  import cp0_unit_pkg::*;
#(
  parameter int NUM_FWD = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_rd,
  input  logic                     stall_nx,
  input  logic [FWD_W*NUM_FWD-1:0] fwd_bus,
  input  logic [4:0]               raddr,
  output logic                     hit,
  output logic [31:0]              hit_data
);

  logic [FWD_W-1:0]   buf_reg [NUM_FWD];
  logic [NUM_FWD-1:0] match;

  // The reading stage stalled while the next stage moves on means a bubble
  // is inserted: buffered writes no longer belong to the read and are dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_FWD; i++) begin
      if (rst || (stall_rd && !stall_nx)) begin
        buf_reg[i] <= '0;
      end else if (!stall_rd) begin
        buf_reg[i] <= fwd_bus[i*FWD_W +: FWD_W];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FWD; gi++) begin : g_match
      assign match[gi] = buf_reg[gi][FWD_WE] && (buf_reg[gi][36:32] == raddr);
    end
  endgenerate

  // Walk from oldest to youngest so the lowest matching index wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = '0;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (match[i]) begin
        hit      = 1'b1;
        hit_data = buf_reg[i][31:0];
      end
    end
  end

endmodule

// File: rtl/cp0_unit.sv
// cp0_unit: CP0 register block (Count, Compare, Status, Cause, EPC,
// BadVAddr, Config) with exception/ERET commit, timer and interrupt request.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   stall                     pipeline stall vector (bypass buffer control)
//   we_i/waddr_i/wdata_i      mtc0 commit
//   raddr_i/data_o            mfc0 read (data_o combinational, bypassed)
//   fwd_bus_i                 in-flight mtc0 writes, channel 0 youngest
//   hw_int_i                  hardware interrupt lines
//   exc_*_i, eret_i           exception / ERET commit from writeback
//   status_o/cause_o/epc_o    architectural register views
//   int_req_o, timer_int_o    interrupt request, Cause.TI
module cp0_unit
  import cp0_unit_pkg::*;
#(
  parameter int          NUM_FWD    = 3,
  parameter int          CNT_DIV    = 2,
  parameter int          HW_INT_W   = 6,
  parameter logic [31:0] STATUS_RST = 32'h1000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [STALL_W-1:0]       stall,
  input  logic                     we_i,
  input  logic [4:0]               waddr_i,
  input  logic [31:0]              wdata_i,
  input  logic [4:0]               raddr_i,
  output logic [31:0]              data_o,
  input  logic [FWD_W*NUM_FWD-1:0] fwd_bus_i,
  input  logic [HW_INT_W-1:0]      hw_int_i,
  input  logic                     exc_valid_i,
  input  logic [4:0]               exc_code_i,
  input  logic [31:0]              exc_pc_i,
  input  logic [31:0]              exc_bad_vaddr_i,
  input  logic                     exc_in_ds_i,
  input  logic                     eret_i,
  output logic [31:0]              status_o,
  output logic [31:0]              cause_o,
  output logic [31:0]              epc_o,
  output logic                     int_req_o,
  output logic                     timer_int_o
);

  localparam logic [3:0] DIV_LAST = 4'(CNT_DIV - 1);

  logic [31:0] count_reg, count_next;
  logic [31:0] compare_reg, compare_next;
  logic [31:0] status_reg, status_next;
  logic [31:0] cause_reg, cause_next;
  logic [31:0] epc_reg, epc_next;
  logic [31:0] badvaddr_reg, badvaddr_next;
  logic [3:0]  div_reg, div_next;
  logic        ti_next;
  logic [5:0]  hw6;
  logic [31:0] rf_data;
  logic        hit;
  logic [31:0] hit_data;
  logic        unused_stall;

  assign unused_stall = ^{stall[STALL_W-1:STALL_NX+1], stall[STALL_RD-1:0]};

  // Map the hardware lines onto the six Cause.IP[7:2] slots.
  genvar gi;
  generate
    for (gi = 0; gi < 6; gi++) begin : g_hw
      if (gi < HW_INT_W) begin : g_on
        assign hw6[gi] = hw_int_i[gi];
      end else begin : g_off
        assign hw6[gi] = 1'b0;
      end
    end
  endgenerate

  // Next-state is built in priority order: mtc0 first, then ERET, then the
  // exception commit, so a later assignment overrides an earlier one.
  always_comb begin
    count_next    = count_reg;
    div_next      = div_reg + 4'd1;
    compare_next  = compare_reg;
    status_next   = status_reg;
    cause_next    = cause_reg;
    epc_next      = epc_reg;
    badvaddr_next = badvaddr_reg;
    ti_next       = cause_reg[CA_TI] ||
                    ((compare_reg != 32'd0) && (count_reg == compare_reg));

    if (div_reg == DIV_LAST) begin
      div_next   = '0;
      count_next = count_reg + 32'd1;
    end

    if (we_i) begin
      case (waddr_i)
        REG_COUNT: begin
          count_next = wdata_i;
          div_next   = '0;
        end
        REG_COMPARE: begin
          compare_next = wdata_i;
          ti_next      = 1'b0;
        end
        REG_STATUS: status_next = wdata_i;
        REG_CAUSE:  cause_next[9:8] = wdata_i[9:8];
        REG_EPC:    epc_next = wdata_i;
        default: ;
      endcase
    end

    // TI feeds IP7 in the same cycle so both rise together.
    cause_next[CA_TI]  = ti_next;
    cause_next[15:10]  = {hw6[5] | ti_next, hw6[4:0]};

    if (eret_i) begin
      status_next[ST_EXL] = 1'b0;
    end

    if (exc_valid_i) begin
      status_next[ST_EXL] = 1'b1;
      cause_next[6:2]     = exc_code_i;
      // A nested exception keeps the original return point.
      if (!status_reg[ST_EXL]) begin
        epc_next          = exc_in_ds_i ? (exc_pc_i - 32'd4) : exc_pc_i;
        cause_next[CA_BD] = exc_in_ds_i;
      end
      if (is_addr_exc(exc_code_i)) begin
        badvaddr_next = exc_bad_vaddr_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg    <= '0;
      compare_reg  <= '0;
      status_reg   <= STATUS_RST;
      cause_reg    <= '0;
      epc_reg      <= '0;
      badvaddr_reg <= '0;
      div_reg      <= '0;
    end else begin
      count_reg    <= count_next;
      compare_reg  <= compare_next;
      status_reg   <= status_next;
      cause_reg    <= cause_next;
      epc_reg      <= epc_next;
      badvaddr_reg <= badvaddr_next;
      div_reg      <= div_next;
    end
  end

  // Config has no writable fields and reads as zero.
  always_comb begin
    case (raddr_i)
      REG_BADVADDR: rf_data = badvaddr_reg;
      REG_COUNT:    rf_data = count_reg;
      REG_COMPARE:  rf_data = compare_reg;
      REG_STATUS:   rf_data = status_reg;
      REG_CAUSE:    rf_data = cause_reg;
      REG_EPC:      rf_data = epc_reg;
      REG_CONFIG:   rf_data = 32'd0;
      default:      rf_data = 32'd0;
    endcase
  end

  cp0_fwd_buf #(
    .NUM_FWD (NUM_FWD)
  ) u_fwd_buf (
    .clk      (clk),
    .rst      (rst),
    .stall_rd (stall[STALL_RD]),
    .stall_nx (stall[STALL_NX]),
    .fwd_bus  (fwd_bus_i),
    .raddr    (raddr_i),
    .hit      (hit),
    .hit_data (hit_data)
  );

  assign data_o      = hit ? hit_data : rf_data;
  assign status_o    = status_reg;
  assign cause_o     = cause_reg;
  assign epc_o       = epc_reg;
  assign timer_int_o = cause_reg[CA_TI];
  assign int_req_o   = status_reg[ST_IE] && !status_reg[ST_EXL] &&
                       |(cause_reg[15:8] & status_reg[15:8]);

endmodule

// File: tb/tb_cp0_unit.sv
// tb_cp0_unit: directed self-checking bench for cp0_unit (default parameters:
// NUM_FWD=3, CNT_DIV=2, HW_INT_W=6, STATUS_RST=32'h1000_0000).
module tb_cp0_unit;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall;
  logic         we_i;
  logic [4:0]   waddr_i;
  logic [31:0]  wdata_i;
  logic [4:0]   raddr_i;
  logic [31:0]  data_o;
  logic [113:0] fwd_bus_i;
  logic [5:0]   hw_int_i;
  logic         exc_valid_i;
  logic [4:0]   exc_code_i;
  logic [31:0]  exc_pc_i;
  logic [31:0]  exc_bad_vaddr_i;
  logic         exc_in_ds_i;
  logic         eret_i;
  logic [31:0]  status_o;
  logic [31:0]  cause_o;
  logic [31:0]  epc_o;
  logic         int_req_o;
  logic         timer_int_o;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cp0_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .we_i            (we_i),
    .waddr_i         (waddr_i),
    .wdata_i         (wdata_i),
    .raddr_i         (raddr_i),
    .data_o          (data_o),
    .fwd_bus_i       (fwd_bus_i),
    .hw_int_i        (hw_int_i),
    .exc_valid_i     (exc_valid_i),
    .exc_code_i      (exc_code_i),
    .exc_pc_i        (exc_pc_i),
    .exc_bad_vaddr_i (exc_bad_vaddr_i),
    .exc_in_ds_i     (exc_in_ds_i),
    .eret_i          (eret_i),
    .status_o        (status_o),
    .cause_o         (cause_o),
    .epc_o           (epc_o),
    .int_req_o       (int_req_o),
    .timer_int_o     (timer_int_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("[TB] %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    we_i = 1'b1; waddr_i = a; wdata_i = d;
    tick();
    we_i = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic [31:0] pc,
                     input logic [31:0] bad, input logic ds);
    exc_valid_i = 1'b1; exc_code_i = code; exc_pc_i = pc;
    exc_bad_vaddr_i = bad; exc_in_ds_i = ds;
    tick();
    exc_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; stall = '0; we_i = 1'b0; waddr_i = '0; wdata_i = '0;
    raddr_i = 5'd12; fwd_bus_i = '0; hw_int_i = '0; exc_valid_i = 1'b0;
    exc_code_i = '0; exc_pc_i = '0; exc_bad_vaddr_i = '0; exc_in_ds_i = 1'b0;
    eret_i = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_status", status_o, 32'h1000_0000);
    check("rst_cause", cause_o, 32'h0);
    check("rst_epc", epc_o, 32'h0);
    check("rst_flags", {30'd0, int_req_o, timer_int_o}, 32'h0);
    raddr_i = 5'd9;
    #1 check("rst_count_read", data_o, 32'h0);

    // Timer: Compare=5 written on the first running edge; Count=5 after 10 edges
    rst = 1'b0;
    mtc0(5'd11, 32'd5);
    repeat (9) tick();
    check("count_after_10", data_o, 32'd5);
    check("ti_not_yet", {31'd0, timer_int_o}, 32'd0);
    tick();
    check("ti_set", {31'd0, timer_int_o}, 32'd1);
    check("cause_ip7", {31'd0, cause_o[15]}, 32'd1);
    mtc0(5'd11, 32'd20);
    check("ti_cleared", {31'd0, timer_int_o}, 32'd0);
    check("cause_ip7_clr", {31'd0, cause_o[15]}, 32'd0);
    raddr_i = 5'd11;
    #1 check("compare_read", data_o, 32'd20);

    // Exception: AdEL in delay slot
    exc(5'd4, 32'h8000_0100, 32'h3, 1'b1);
    check("exc1_epc", epc_o, 32'h8000_00FC);
    check("exc1_cause", cause_o & 32'h8000_007C, 32'h8000_0010);
    check("exc1_status", status_o, 32'h1000_0002);
    raddr_i = 5'd8;
    #1 check("exc1_badvaddr", data_o, 32'h3);

    // Nested exception while EXL=1: EPC/BD/BadVAddr unchanged
    exc(5'd8, 32'h200, 32'h55, 1'b0);
    check("exc2_epc", epc_o, 32'h8000_00FC);
    check("exc2_cause", cause_o & 32'h8000_007C, 32'h8000_0020);
    check("exc2_badvaddr", data_o, 32'h3);
    eret_i = 1'b1; tick(); eret_i = 1'b0;
    check("eret_status", status_o, 32'h1000_0000);

    // mtc0 Status=0 together with an exception: EXL still set
    we_i = 1'b1; waddr_i = 5'd12; wdata_i = 32'h0;
    exc(5'd8, 32'h300, 32'h0, 1'b0);
    we_i = 1'b0;
    check("mtc0_exc_status", status_o, 32'h2);
    check("mtc0_exc_epc", epc_o, 32'h300);
    check("mtc0_exc_bd", {31'd0, cause_o[31]}, 32'd0);

    // Exception and ERET together: ERET dropped
    eret_i = 1'b1; tick(); eret_i = 1'b0;
    eret_i = 1'b1;
    exc(5'd5, 32'h400, 32'h1234, 1'b0);
    eret_i = 1'b0;
    check("exc_eret_status", status_o, 32'h2);
    check("exc_eret_epc", epc_o, 32'h400);
    #1 check("exc_eret_badvaddr", data_o, 32'h1234);

    // Interrupt request through IM2 / IP2
    hw_int_i = 6'b000001;
    mtc0(5'd12, 32'h0000_0401);
    tick();
    check("int_req_on", {31'd0, int_req_o}, 32'd1);
    exc(5'd0, 32'h500, 32'h0, 1'b0);
    check("int_req_exl", {31'd0, int_req_o}, 32'd0);
    check("int_status", status_o, 32'h0000_0403);
    hw_int_i = '0;

    // Bypass: channels 0 and 2 write Status, channel 0 wins
    raddr_i = 5'd12;
    fwd_bus_i = {1'b1, 5'd12, 32'hB, 38'd0, 1'b1, 5'd12, 32'hA};
    tick();
    check("byp_prio", data_o, 32'hA);
    fwd_bus_i = {1'b1, 5'd12, 32'hB, 38'd0, 1'b1, 5'd14, 32'hA};
    tick();
    check("byp_ch2", data_o, 32'hB);
    fwd_bus_i = '0;
    stall = 6'b011000;
    tick();
    check("byp_hold", data_o, 32'hB);
    stall = 6'b001000;
    tick();
    check("byp_clear", data_o, 32'h0000_0403);
    raddr_i = 5'd3;
    #1 check("unimpl_read", data_o, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
